// File: rtl/hms_timekeeper.sv
// Packed-BCD hh:mm:ss timekeeper with a two-button (mode/inc) set FSM.
// Optional macro HOUR12_EN selects a 12-hour display with a PM flag; undefined gives 24-hour time.
module hms_timekeeper #(
    parameter int unsigned CLEAR_SEC_ON_SET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic [1:0] mode,
    output logic       min_carry,
    output logic       pm
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_e;

`ifdef HOUR12_EN
    localparam logic [7:0] HR_RESET = 8'h12;
`else
    localparam logic [7:0] HR_RESET = 8'h00;
`endif

    state_e     state_q, state_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hr_q, hr_d;
    logic       carry_q, carry_d;
    logic [2:0] mode_sync_q, inc_sync_q;
    logic       mode_press, inc_press;
    logic       hr_step;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // [0]=s1, [1]=s2, [2]=s3; a press is the rising edge seen between s2 and s3
    assign mode_press = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_press  = inc_sync_q[1]  & ~inc_sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            state_q     <= RUN;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= HR_RESET;
            carry_q     <= 1'b0;
        end else begin
            mode_sync_q <= {mode_sync_q[1:0], btn_mode};
            inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            carry_q     <= carry_d;
        end
    end

`ifdef HOUR12_EN
    logic pm_q, pm_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pm_q <= 1'b0;
        else        pm_q <= pm_d;
    end

    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        carry_d = 1'b0;
        hr_step = 1'b0;
`ifdef HOUR12_EN
        pm_d    = pm_q;
`endif

        unique case (state_q)
            RUN: begin
                if (sec_tick) begin
                    if (sec_q == 8'h59) begin
                        sec_d   = '0;
                        carry_d = 1'b1;
                        if (min_q == 8'h59) begin
                            min_d   = '0;
                            hr_step = 1'b1;
                        end else begin
                            min_d = bcd_inc(min_q);
                        end
                    end else begin
                        sec_d = bcd_inc(sec_q);
                    end
                end
                if (mode_press) state_d = SET_HR;
            end
            SET_HR: begin
                if (inc_press)  hr_step = 1'b1;
                if (mode_press) state_d = SET_MIN;
            end
            SET_MIN: begin
                if (inc_press) min_d = (min_q == 8'h59) ? '0 : bcd_inc(min_q);
                // Leaving SET_MIN: any tick on this edge is dropped, not applied
                if (mode_press) begin
                    state_d = RUN;
                    if (CLEAR_SEC_ON_SET != 0) sec_d = '0;
                end
            end
            default: state_d = RUN;
        endcase

        // Shared by RUN rollover and SET_HR increment so both wrap and flip PM identically
        if (hr_step) begin
`ifdef HOUR12_EN
            if (hr_q == 8'h12) begin
                hr_d = 8'h01;
            end else begin
                hr_d = bcd_inc(hr_q);
                if (hr_q == 8'h11) pm_d = ~pm_q;
            end
`else
            hr_d = (hr_q == 8'h23) ? '0 : bcd_inc(hr_q);
`endif
        end
    end

    assign sec_bcd   = sec_q;
    assign min_bcd   = min_q;
    assign hr_bcd    = hr_q;
    assign mode      = state_q;
    assign min_carry = carry_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Self-checking bench for hms_timekeeper: directed scenarios plus random stimulus
// against a seconds-of-day reference model.
module tb_hms_timekeeper;

    localparam int unsigned CLEAR = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sec_tick, btn_mode, btn_inc;
    logic [7:0] sec_bcd, min_bcd, hr_bcd;
    logic [1:0] mode;
    logic       min_carry, pm;

    always #5 clk = ~clk;

    hms_timekeeper #(.CLEAR_SEC_ON_SET(CLEAR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_tick  (sec_tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hr_bcd    (hr_bcd),
        .mode      (mode),
        .min_carry (min_carry),
        .pm        (pm)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: 24h time held as plain integers, button levels per sampled edge
    int m_h, m_m, m_s, m_mode;
    bit m_carry;
    bit mh[3];
    bit ih[3];

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] exp_hr();
`ifdef HOUR12_EN
        int x = m_h % 12;
        return to_bcd((x == 0) ? 12 : x);
`else
        return to_bcd(m_h);
`endif
    endfunction

    function automatic bit exp_pm();
`ifdef HOUR12_EN
        return (m_h >= 12);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_carry = 0;
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0;
            ih[i] = 0;
        end
    endtask

    task automatic model_edge(input bit t, input bit bm, input bit bi);
        // press = level two edges ago high, three edges ago low
        bit mp = mh[1] & !mh[2];
        bit ip = ih[1] & !ih[2];
        int tod;
        mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = bm;
        ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = bi;
        m_carry = 0;
        case (m_mode)
            0: begin
                if (t) begin
                    m_carry = (m_s == 59);
                    tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = tod / 3600;
                    m_m = (tod / 60) % 60;
                    m_s = tod % 60;
                end
                if (mp) m_mode = 1;
            end
            1: begin
                if (ip) m_h = (m_h + 1) % 24;
                if (mp) m_mode = 2;
            end
            default: begin
                if (ip) m_m = (m_m + 1) % 60;
                if (mp) begin
                    m_mode = 0;
                    if (CLEAR != 0) m_s = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        bit ok;
        check("sec", sec_bcd, to_bcd(m_s));
        check("min", min_bcd, to_bcd(m_m));
        check("hr", hr_bcd, exp_hr());
        check("mode", mode, m_mode);
        check("min_carry", min_carry, m_carry);
        check("pm", pm, exp_pm());
        ok = (sec_bcd[7:4] <= 5) && (sec_bcd[3:0] <= 9) &&
             (min_bcd[7:4] <= 5) && (min_bcd[3:0] <= 9) &&
             (hr_bcd[7:4] <= 2) && (hr_bcd[3:0] <= 9) && (mode != 2'b11);
        check("bcd_range", ok, 1);
    endtask

    task automatic step(input bit t, input bit bm, input bit bi);
        sec_tick = t; btn_mode = bm; btn_inc = bi;
        @(posedge clk);
        model_edge(t, bm, bi);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input bit bm, input bit bi, input bit t);
        step(t, bm, bi);
        repeat (3) step(t, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        sec_tick = 0; btn_mode = 0; btn_inc = 0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit bm, bi;
        rst_n = 1'b0; sec_tick = 0; btn_mode = 0; btn_inc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // 60 ticks: one minute, carry pulse for exactly one cycle
        repeat (60) step(1, 0, 0);
        check("t60_sec", sec_bcd, 8'h00);
        check("t60_min", min_bcd, 8'h01);
        check("t60_carry", min_carry, 1);
        step(0, 0, 0);
        check("t60_carry_low", min_carry, 0);

        // Mode button latency and hold behaviour
        step(0, 1, 0);
        step(0, 1, 0);
        check("mode_edge2", mode, 2'b00);
        step(0, 1, 0);
        check("mode_edge3", mode, 2'b01);
        repeat (18) step(0, 1, 0);
        check("mode_held", mode, 2'b01);
        repeat (3) step(0, 0, 0);
        press(1, 0, 0);
        check("mode_setmin", mode, 2'b10);
        press(1, 0, 0);
        check("mode_run", mode, 2'b00);
        check("sec_cleared", sec_bcd, 8'h00);

        // 25 inc presses in SET_HR with ticks running: hour wraps, seconds frozen
        do_reset();
        press(1, 0, 0);
        repeat (25) press(0, 1, 1);
        check("hr_25inc", hr_bcd, 8'h01);
        check("sec_frozen", sec_bcd, 8'h00);

        // Preload 23:59:58 and roll over the day
        do_reset();
        press(1, 0, 0);
        repeat (23) press(0, 1, 0);
        press(1, 0, 0);
        repeat (59) press(0, 1, 0);
        press(1, 0, 0);
        repeat (58) step(1, 0, 0);
        check("pre_sec", sec_bcd, 8'h58);
        check("pre_min", min_bcd, 8'h59);
`ifdef HOUR12_EN
        check("pre_hr", hr_bcd, 8'h11);
        check("pre_pm", pm, 1);
`else
        check("pre_hr", hr_bcd, 8'h23);
`endif
        repeat (2) step(1, 0, 0);
        check("roll_sec", sec_bcd, 8'h00);
        check("roll_min", min_bcd, 8'h00);
`ifdef HOUR12_EN
        check("roll_hr", hr_bcd, 8'h12);
`else
        check("roll_hr", hr_bcd, 8'h00);
`endif
        check("roll_pm", pm, 0);

        // Tick and mode press on the same edge, in RUN then in SET_MIN
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("same_run_mode", mode, 2'b01);
        check("same_run_sec", sec_bcd, 8'h01);
        press(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("same_setmin_mode", mode, 2'b00);
        check("same_setmin_sec", sec_bcd, 8'h00);

        // Async reset in the middle of SET_MIN
        do_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        repeat (37) press(0, 1, 0);
        check("pre_rst_min", min_bcd, 8'h37);
        do_reset();
        check("rst_min", min_bcd, 8'h00);
        check("rst_mode", mode, 2'b00);
        step(1, 0, 0);
        check("post_rst_sec", sec_bcd, 8'h01);

        // Random stimulus against the model
        bm = 0; bi = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                bm = 0; bi = 0;
            end
            if ($urandom_range(0, 5) == 0) bm = ~bm;
            if ($urandom_range(0, 2) == 0) bi = ~bi;
            step($urandom_range(0, 2) == 0, bm, bi);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
